massbus_mux: RTL
================

Name: massbus_mux

Overview:
- Parametrised Massbus fan-out between one RH11 master and NUM_UNITS drive slaves (disk or tape).
- Routes register reads/writes to the drive selected by UNIT, with timeout and nonexistent-drive reporting.
- Binds the data-transfer handshake (REQO/ACKI/DATA) to the drive that received GO until that transfer completes.
- Registers per-drive status vectors toward the RH11.

Parameters:
NUM_UNITS, 8, number of drive ports (1..8); UNIT values >= NUM_UNITS are nonexistent
DATA_WIDTH, 36, data path width (word bit 0 is MSB)
REG_TIMEOUT, 31, cycles to wait for a drive REGACK before declaring nonexistent drive (NED)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m_init  in  1  master initialize, broadcast to all drives
m_read / m_write  in  1 each  register read/write strobe, one-cycle pulse
m_regsel  in  5  register address
m_unit  in  3  unit select
m_fun  in  5  function code
m_go  in  1  function GO strobe, one cycle
m_datai  in  DATA_WIDTH  write data toward drive
m_acki  in  1  data acknowledge toward active drive
m_reqo  out  1  data request from active drive
m_datao  out  DATA_WIDTH  data from active drive
m_regdat  out  16  register read data
m_regack  out  1  register access complete, one cycle
m_ned  out  1  nonexistent drive, valid with m_regack
m_busy  out  1  transfer in progress
m_ata  out  8  attention vector, bits >= NUM_UNITS zero
m_dpr / m_dva / m_dry  out  1 each  status of drive selected by m_unit
s_read / s_write / s_go / s_init  out  NUM_UNITS each  per-drive strobes
s_regsel  out  5  broadcast register address
s_fun  out  5  broadcast function
s_datai  out  DATA_WIDTH  broadcast write data
s_acki  out  NUM_UNITS  per-drive acknowledge
s_reqo / s_regack / s_ata / s_dpr / s_dva / s_dry  in  NUM_UNITS each  per-drive status
s_regdat  in  NUM_UNITS*16  per-drive register data
s_datao  in  NUM_UNITS*DATA_WIDTH  per-drive data

Behaviour:
- Reset: every output is 0. FSM enters IDLE, active unit = 0, timeout counter = 0.
- Register FSM states: R_IDLE, R_WAIT.
  - R_IDLE: on m_read or m_write, latch unit, regsel and write data.
    - Unit >= NUM_UNITS, or s_dpr[unit] = 0: next cycle emits m_regack = 1, m_ned = 1, m_regdat = 0. Stay in R_IDLE.
    - Otherwise: assert the one-cycle s_read/s_write[unit] registered (1 cycle after the master strobe), then go to R_WAIT.
  - R_WAIT: count cycles.
    - s_regack[unit] seen: m_regack = 1 and m_regdat = s_regdat[unit], registered, next cycle. Return to R_IDLE.
    - Counter reaches REG_TIMEOUT: m_regack = 1, m_ned = 1, m_regdat = 0. Return to R_IDLE.
  - Strobes arriving in R_WAIT are ignored (the master serialises register accesses).
- Transfer FSM states: X_IDLE, X_ACTIVE.
  - m_go with a present unit: forward s_go[unit] registered, latch the active unit, enter X_ACTIVE, m_busy = 1.
  - m_go to an absent unit: no s_go, m_busy stays 0.
  - X_ACTIVE routing: m_reqo = s_reqo[active] and m_datao = s_datao[active], combinational. s_acki[active] = m_acki, all other s_acki = 0. Other drives' s_reqo are ignored.
  - Leave X_ACTIVE when s_dry[active] rises (0->1 edge detected after entry), or on m_init. m_busy drops 1 cycle after the exit condition.
  - m_go during X_ACTIVE: forwarded to its target drive (non-data functions such as seek), but the active unit does not change.
  - Register accesses are allowed concurrently with X_ACTIVE.
- m_init: s_init = all ones, same cycle (combinational). Both FSMs return to idle next cycle. m_regack is not generated for an aborted R_WAIT access.
- m_ata: s_ata registered, 1-cycle latency, zero-extended to 8 bits.
- m_dpr/m_dva/m_dry: mux by the live m_unit. Return 0 for an out-of-range unit.
- A simultaneous s_regack and timeout in the same cycle: regack wins, m_ned = 0.

Decomposition:
- Package massbus_mux_pkg holds:
  - register and transfer FSM state enums
  - constant NED_DATA = 16'h0000
  - function unit_valid(unit, NUM_UNITS)
- One sub-module, massbus_mux_regctl: register FSM plus timeout counter. The transfer FSM, muxing and ATA register stay in the top level.

Test Plan:
- Read unit 2, regsel 5'o06; drive 2 acks after 3 cycles with 16'o020000 -> one m_regack pulse, m_regdat = 16'o020000, m_ned = 0, s_read asserted only on bit 2.
- Write to unit 6 with NUM_UNITS = 4 -> m_regack + m_ned the next cycle, no s_write bit set. Read of a present drive that never acks -> m_ned after exactly REG_TIMEOUT+1 cycles.
- GO to unit 1, then drive 1 and drive 3 both assert reqo -> m_reqo follows drive 1 only, m_acki reaches s_acki[1] only. s_dry[1] rising -> m_busy = 0 the following cycle.
- Register read of unit 0 during a unit 1 transfer -> completes normally, transfer routing undisturbed.
- m_init asserted in R_WAIT and X_ACTIVE -> s_init all ones, no m_regack, m_busy = 0, both FSMs idle the next cycle.
- Async rst asserted mid-transfer without a clock edge -> all outputs 0 immediately.
- s_ata = 4'b1010 (NUM_UNITS = 4) -> m_ata = 8'h0A one cycle later.

Source files
------------

// File: rtl/massbus_mux_pkg.sv
// Shared types and helpers for the Massbus fan-out between one RH11 and its drives.
package massbus_mux_pkg;

  typedef enum logic {R_IDLE, R_WAIT}   reg_state_e;
  typedef enum logic {X_IDLE, X_ACTIVE} xfer_state_e;

  localparam logic [15:0] NED_DATA = 16'h0000;

  function automatic logic unit_valid(input logic [2:0] unit, input int num_units);
    return int'(unit) < num_units;
  endfunction

endpackage

// File: rtl/massbus_mux_regctl.sv
// Register-access sequencer: forwards one read/write to the selected drive and
// reports either its REGACK data or a nonexistent-drive timeout.
module massbus_mux_regctl
  import massbus_mux_pkg::*;
#(
  parameter int NUM_UNITS   = 8,
  parameter int DATA_WIDTH  = 36,
  parameter int REG_TIMEOUT = 31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_i,
  input  logic                      read_i,
  input  logic                      write_i,
  input  logic [2:0]                unit_i,
  input  logic [4:0]                regsel_i,
  input  logic [DATA_WIDTH-1:0]     datai_i,
  input  logic [NUM_UNITS-1:0]      dpr_i,
  input  logic [NUM_UNITS-1:0]      regack_i,
  input  logic [NUM_UNITS*16-1:0]   regdat_i,
  output logic [NUM_UNITS-1:0]      s_read_o,
  output logic [NUM_UNITS-1:0]      s_write_o,
  output logic [4:0]                s_regsel_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic                      regack_o,
  output logic                      ned_o,
  output logic [15:0]               regdat_o
);

  localparam int CW = $clog2(REG_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(REG_TIMEOUT - 1);

  reg_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            unit_q, unit_d;
  logic [4:0]            regsel_q, regsel_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_UNITS-1:0]  read_q, read_d, write_q, write_d;
  logic                  regack_q, regack_d, ned_q, ned_d;
  logic [15:0]           regdat_q, regdat_d;

  logic [NUM_UNITS-1:0]  new_sel, wait_sel;
  logic [15:0]           ack_data;
  logic                  ack_hit, present;

  always_comb begin
    new_sel  = '0;
    wait_sel = '0;
    ack_data = NED_DATA;
    for (int i = 0; i < NUM_UNITS; i++) begin
      new_sel[i]  = (unit_i == 3'(i));
      wait_sel[i] = (unit_q == 3'(i));
      if (wait_sel[i]) ack_data = regdat_i[i*16 +: 16];
    end
    ack_hit = |(wait_sel & regack_i);
    present = unit_valid(unit_i, NUM_UNITS) && |(new_sel & dpr_i);
  end

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    unit_d   = unit_q;
    regsel_d = regsel_q;
    wdata_d  = wdata_q;
    read_d   = '0;
    write_d  = '0;
    regack_d = 1'b0;
    ned_d    = 1'b0;
    regdat_d = NED_DATA;
    if (init_i) begin
      state_d = R_IDLE;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (read_i || write_i) begin
            unit_d   = unit_i;
            regsel_d = regsel_i;
            wdata_d  = datai_i;
            if (present) begin
              read_d  = read_i ? new_sel : '0;
              write_d = (write_i && !read_i) ? new_sel : '0;
              cnt_d   = '0;
              state_d = R_WAIT;
            end else begin
              regack_d = 1'b1;
              ned_d    = 1'b1;
            end
          end
        end
        R_WAIT: begin
          // A REGACK arriving on the timeout cycle still counts as a good access.
          if (ack_hit) begin
            regack_d = 1'b1;
            regdat_d = ack_data;
            state_d  = R_IDLE;
          end else if (cnt_q == LAST_CNT) begin
            regack_d = 1'b1;
            ned_d    = 1'b1;
            state_d  = R_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= R_IDLE;
      cnt_q    <= '0;
      unit_q   <= '0;
      regsel_q <= '0;
      wdata_q  <= '0;
      read_q   <= '0;
      write_q  <= '0;
      regack_q <= 1'b0;
      ned_q    <= 1'b0;
      regdat_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      unit_q   <= unit_d;
      regsel_q <= regsel_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
      regack_q <= regack_d;
      ned_q    <= ned_d;
      regdat_q <= regdat_d;
    end
  end

  assign s_read_o   = read_q;
  assign s_write_o  = write_q;
  assign s_regsel_o = regsel_q;
  assign wdata_o    = wdata_q;
  assign regack_o   = regack_q;
  assign ned_o      = ned_q;
  assign regdat_o   = regdat_q;

endmodule

// File: rtl/massbus_mux.sv
// Massbus fan-out: register access via massbus_mux_regctl, data-transfer binding to
// the drive that accepted GO, and status/attention routing back to the RH11.
module massbus_mux
  import massbus_mux_pkg::*;
#(
  parameter int NUM_UNITS   = 8,
  parameter int DATA_WIDTH  = 36,
  parameter int REG_TIMEOUT = 31
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            m_init,
  input  logic                            m_read,
  input  logic                            m_write,
  input  logic [4:0]                      m_regsel,
  input  logic [2:0]                      m_unit,
  input  logic [4:0]                      m_fun,
  input  logic                            m_go,
  input  logic [DATA_WIDTH-1:0]           m_datai,
  input  logic                            m_acki,
  output logic                            m_reqo,
  output logic [DATA_WIDTH-1:0]           m_datao,
  output logic [15:0]                     m_regdat,
  output logic                            m_regack,
  output logic                            m_ned,
  output logic                            m_busy,
  output logic [7:0]                      m_ata,
  output logic                            m_dpr,
  output logic                            m_dva,
  output logic                            m_dry,
  output logic [NUM_UNITS-1:0]            s_read,
  output logic [NUM_UNITS-1:0]            s_write,
  output logic [NUM_UNITS-1:0]            s_go,
  output logic [NUM_UNITS-1:0]            s_init,
  output logic [4:0]                      s_regsel,
  output logic [4:0]                      s_fun,
  output logic [DATA_WIDTH-1:0]           s_datai,
  output logic [NUM_UNITS-1:0]            s_acki,
  input  logic [NUM_UNITS-1:0]            s_reqo,
  input  logic [NUM_UNITS-1:0]            s_regack,
  input  logic [NUM_UNITS-1:0]            s_ata,
  input  logic [NUM_UNITS-1:0]            s_dpr,
  input  logic [NUM_UNITS-1:0]            s_dva,
  input  logic [NUM_UNITS-1:0]            s_dry,
  input  logic [NUM_UNITS*16-1:0]         s_regdat,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] s_datao
);

  xfer_state_e           x_state_q, x_state_d;
  logic [2:0]            active_q, active_d;
  logic [NUM_UNITS-1:0]  s_go_q, s_go_d, dry_q;
  logic [4:0]            fun_q, fun_d;
  logic [7:0]            ata_q, ata_d;
  logic [NUM_UNITS-1:0]  unit_sel, active_sel;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  go_present, dry_rise, xfer_active;

  massbus_mux_regctl #(
    .NUM_UNITS  (NUM_UNITS),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_TIMEOUT(REG_TIMEOUT)
  ) u_regctl (
    .clk       (clk),
    .rst       (rst),
    .init_i    (m_init),
    .read_i    (m_read),
    .write_i   (m_write),
    .unit_i    (m_unit),
    .regsel_i  (m_regsel),
    .datai_i   (m_datai),
    .dpr_i     (s_dpr),
    .regack_i  (s_regack),
    .regdat_i  (s_regdat),
    .s_read_o  (s_read),
    .s_write_o (s_write),
    .s_regsel_o(s_regsel),
    .wdata_o   (wdata),
    .regack_o  (m_regack),
    .ned_o     (m_ned),
    .regdat_o  (m_regdat)
  );

  always_comb begin
    unit_sel   = '0;
    active_sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_sel[i]   = (m_unit == 3'(i));
      active_sel[i] = (active_q == 3'(i));
    end
    go_present  = unit_valid(m_unit, NUM_UNITS) && |(unit_sel & s_dpr);
    xfer_active = (x_state_q == X_ACTIVE);
    dry_rise    = |(active_sel & s_dry & ~dry_q);
  end

  // A GO during a transfer still reaches its drive (e.g. a seek) but never rebinds the data path.
  always_comb begin
    x_state_d = x_state_q;
    active_d  = active_q;
    s_go_d    = '0;
    fun_d     = fun_q;
    if (m_init) begin
      x_state_d = X_IDLE;
    end else begin
      if (m_go && go_present) begin
        s_go_d = unit_sel;
        fun_d  = m_fun;
        if (!xfer_active) begin
          x_state_d = X_ACTIVE;
          active_d  = m_unit;
        end
      end
      if (xfer_active && dry_rise) x_state_d = X_IDLE;
    end
  end

  always_comb begin
    ata_d = '0;
    ata_d[NUM_UNITS-1:0] = s_ata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_state_q <= X_IDLE;
      active_q  <= '0;
      s_go_q    <= '0;
      fun_q     <= '0;
      dry_q     <= '0;
      ata_q     <= '0;
    end else begin
      x_state_q <= x_state_d;
      active_q  <= active_d;
      s_go_q    <= s_go_d;
      fun_q     <= fun_d;
      dry_q     <= s_dry;
      ata_q     <= ata_d;
    end
  end

  always_comb begin
    m_reqo  = 1'b0;
    m_datao = '0;
    s_acki  = '0;
    if (xfer_active) begin
      m_reqo = |(active_sel & s_reqo);
      s_acki = active_sel & {NUM_UNITS{m_acki}};
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (active_sel[i]) m_datao = s_datao[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pass-through outputs are gated by rst so the whole port reads zero while reset is held.
  assign m_dpr   = !rst && |(unit_sel & s_dpr);
  assign m_dva   = !rst && |(unit_sel & s_dva);
  assign m_dry   = !rst && |(unit_sel & s_dry);
  assign s_init  = rst ? '0 : {NUM_UNITS{m_init}};
  assign s_datai = rst ? '0 : ((|s_write) ? wdata : m_datai);

  assign m_busy = xfer_active;
  assign m_ata  = ata_q;
  assign s_go   = s_go_q;
  assign s_fun  = fun_q;

endmodule
